// File: rtl/wrom_pkg.sv
// Shared types and default constants for the weight ROM arbiter.
package wrom_pkg;

   localparam int DEF_ADDR_W      = 10;
   localparam int DEF_ROM_LAT     = 2;
   localparam int DEF_TOTAL_BYTES = 715;

   // Tag fields are sized for the largest supported configuration (8 requesters, 16-bit length)
   localparam int TAG_ID_W  = 3;
   localparam int TAG_IDX_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } state_t;

   typedef struct packed {
      logic                 valid;
      logic [TAG_ID_W-1:0]  id;
      logic [TAG_IDX_W-1:0] idx;
      logic                 last;
   } tag_t;

endpackage

// File: rtl/wrom_tag_pipe.sv
// Resettable delay line that keeps burst tags aligned with ROM read data.
module wrom_tag_pipe
   import wrom_pkg::*;
#(
   parameter int DEPTH = DEF_ROM_LAT
) (
   input  logic clk,
   input  logic rst,
   input  tag_t tag_in,
   output tag_t tag_out
);

   tag_t stage_reg [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
               if (rst) stage_reg[0] <= '0;
               else     stage_reg[0] <= tag_in;
            end
         end else begin : g_body
            always_ff @(posedge clk) begin
               if (rst) stage_reg[gi] <= '0;
               else     stage_reg[gi] <= stage_reg[gi-1];
            end
         end
      end
   endgenerate

   assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/weight_rom_arbiter.sv
// Round-robin burst arbiter in front of the shared weight ROM; streams tagged bytes.
// Optional WROM_ARB_CHECKSUM_EN adds a per-burst mod-256 byte sum output.
module weight_rom_arbiter
   import wrom_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int LEN_W       = 10,
   parameter int ROM_LAT     = DEF_ROM_LAT,
   parameter int TOTAL_BYTES = DEF_TOTAL_BYTES,
   localparam int ID_W       = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*ADDR_W-1:0] req_base,
   input  logic [N_REQ*LEN_W-1:0]  req_len,
   output logic                    rom_en,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [7:0]              rom_dout,
   output logic                    dout_valid,
   output logic [7:0]              dout_data,
   output logic [ID_W-1:0]         dout_id,
   output logic [LEN_W-1:0]        dout_idx,
   output logic                    dout_last,
   output logic                    err,
`ifdef WROM_ARB_CHECKSUM_EN
   output logic [7:0]              burst_sum,
`endif
   output logic                    busy
);

   localparam int SUM_W = ADDR_W + 1;

   state_t            state_reg;
   logic [ID_W-1:0]   last_grant_reg, id_reg, err_id_reg;
   logic [LEN_W-1:0]  len_reg, idx_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic              last_reg, rom_en_reg, err_reg;

   logic [ID_W-1:0]   cand_id, pick_id;
   logic              pick_found, pick_illegal, accept;
   logic [ADDR_W-1:0] pick_base;
   logic [LEN_W-1:0]  pick_len;
   logic [SUM_W-1:0]  pick_end;

   tag_t tag_in, tag_out;
   logic tag_unused;

   // Search begins just after the previous winner, so every requester gets a turn
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      cand_id    = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand_id = ID_W'((int'(last_grant_reg) + i) % N_REQ);
         if (!pick_found && req_valid[cand_id]) begin
            pick_found = 1'b1;
            pick_id    = cand_id;
         end
      end
      pick_base    = req_base[int'(pick_id)*ADDR_W +: ADDR_W];
      pick_len     = req_len[int'(pick_id)*LEN_W +: LEN_W];
      pick_end     = SUM_W'(pick_base) + SUM_W'(pick_len);
      pick_illegal = (pick_len == '0) || (pick_end > SUM_W'(TOTAL_BYTES));
      accept       = pick_found && (state_reg == IDLE) && !rst;
      req_ready    = accept ? (N_REQ'(1) << pick_id) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         last_grant_reg <= ID_W'(N_REQ - 1);
         id_reg         <= '0;
         len_reg        <= '0;
         idx_reg        <= '0;
         addr_reg       <= '0;
         last_reg       <= 1'b0;
         rom_en_reg     <= 1'b0;
         err_reg        <= 1'b0;
         err_id_reg     <= '0;
      end else begin
         err_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  last_grant_reg <= pick_id;
                  if (pick_illegal) begin
                     err_reg    <= 1'b1;
                     err_id_reg <= pick_id;
                  end else begin
                     state_reg  <= ISSUE;
                     id_reg     <= pick_id;
                     len_reg    <= pick_len;
                     idx_reg    <= '0;
                     addr_reg   <= pick_base;
                     last_reg   <= (pick_len == LEN_W'(1));
                     rom_en_reg <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (last_reg) begin
                  rom_en_reg <= 1'b0;
                  state_reg  <= DRAIN;
               end else begin
                  addr_reg <= addr_reg + 1'b1;
                  idx_reg  <= idx_reg + 1'b1;
                  last_reg <= (idx_reg + LEN_W'(2) == len_reg);
               end
            end
            DRAIN: begin
               if (tag_out.valid && tag_out.last) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_comb begin
      tag_in = '0;
      if (rom_en_reg) begin
         tag_in.valid = 1'b1;
         tag_in.id    = TAG_ID_W'(id_reg);
         tag_in.idx   = TAG_IDX_W'(idx_reg);
         tag_in.last  = last_reg;
      end
   end

   wrom_tag_pipe #(.DEPTH(ROM_LAT)) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   assign tag_unused = &{1'b0, tag_out};

   assign rom_en     = rom_en_reg;
   assign rom_addr   = addr_reg;
   assign dout_valid = tag_out.valid;
   assign dout_data  = rom_dout;
   assign dout_id    = err_reg ? err_id_reg : tag_out.id[ID_W-1:0];
   assign dout_idx   = tag_out.idx[LEN_W-1:0];
   assign dout_last  = tag_out.last;
   assign err        = err_reg;
   assign busy       = (state_reg != IDLE);

`ifdef WROM_ARB_CHECKSUM_EN
   logic [7:0] sum_reg;

   always_ff @(posedge clk) begin
      if (rst)                sum_reg <= 8'h00;
      else if (accept)        sum_reg <= 8'h00;
      else if (tag_out.valid) sum_reg <= sum_reg + rom_dout;
   end

   // Include the byte on the bus so the total is complete alongside dout_last
   assign burst_sum = sum_reg + (tag_out.valid ? rom_dout : 8'h00);
`endif

endmodule

// File: tb/tb_weight_rom_arbiter.sv
// Scoreboard bench for weight_rom_arbiter: grant watcher pushes expectations, negedge monitor checks.
`timescale 1ns/1ps
module tb_weight_rom_arbiter;

   localparam int N_REQ  = 4;
   localparam int ADDR_W = 10;
   localparam int LEN_W  = 10;
   localparam int ID_W   = 2;
   localparam int TOTAL  = 715;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [N_REQ-1:0]        req_valid = '0;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ*ADDR_W-1:0] req_base = '0;
   logic [N_REQ*LEN_W-1:0]  req_len = '0;
   logic                    rom_en;
   logic [ADDR_W-1:0]       rom_addr;
   logic [7:0]              rom_dout = 8'h00;
   logic                    dout_valid;
   logic [7:0]              dout_data;
   logic [ID_W-1:0]         dout_id;
   logic [LEN_W-1:0]        dout_idx;
   logic                    dout_last;
   logic                    err;
   logic                    busy;
`ifdef WROM_ARB_CHECKSUM_EN
   logic [7:0]              burst_sum;
`endif

   always #5 clk = ~clk;

   weight_rom_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_base   (req_base),
      .req_len    (req_len),
      .rom_en     (rom_en),
      .rom_addr   (rom_addr),
      .rom_dout   (rom_dout),
      .dout_valid (dout_valid),
      .dout_data  (dout_data),
      .dout_id    (dout_id),
      .dout_idx   (dout_idx),
      .dout_last  (dout_last),
      .err        (err),
`ifdef WROM_ARB_CHECKSUM_EN
      .burst_sum  (burst_sum),
`endif
      .busy       (busy)
   );

   // Two-cycle ROM model
   logic [7:0] rom_mem [1024];
   logic [7:0] rom_q1 = 8'h00;
   always @(posedge clk) begin
      rom_q1   <= rom_mem[rom_addr];
      rom_dout <= rom_q1;
   end

   typedef struct {
      int         cyc;
      logic [7:0] data;
      int         id;
      int         idx;
      logic       last;
      logic [7:0] sum;
   } byte_exp_t;

   byte_exp_t exp_q[$];
   int err_cyc_q[$], err_id_q[$];
   int addr_cyc_q[$], addr_q[$];
   int gid_q[$], gcyc_q[$];
   int n_cmp = 0, n_bad = 0;
   int cyc = 0;
   int accept_cyc = 0;
   int cfg_base[N_REQ], cfg_len[N_REQ], remaining[N_REQ];
   logic [7:0] w_sum;

   function automatic void check(string name, longint act, longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic void fail_now(string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endfunction

   always @(posedge clk) cyc++;

   // Grant watcher: turns each observed handshake into expected ROM reads and output bytes
   always @(negedge clk) begin
      if (req_ready != '0) check("ready_onehot", $countones(req_ready), 1);
      for (int i = 0; i < N_REQ; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            gid_q.push_back(i);
            gcyc_q.push_back(cyc);
            remaining[i]--;
            accept_cyc = cyc;
            $display("cycle %0d: accept req%0d base=%0d len=%0d", cyc, i, cfg_base[i], cfg_len[i]);
            if (cfg_len[i] == 0 || cfg_base[i] + cfg_len[i] > TOTAL) begin
               err_cyc_q.push_back(cyc + 1);
               err_id_q.push_back(i);
            end else begin
               w_sum = 8'h00;
               for (int k = 0; k < cfg_len[i]; k++) begin
                  w_sum = w_sum + rom_mem[cfg_base[i] + k];
                  addr_cyc_q.push_back(cyc + 1 + k);
                  addr_q.push_back(cfg_base[i] + k);
                  exp_q.push_back('{cyc + 3 + k, rom_mem[cfg_base[i] + k], i, k,
                                    (k == cfg_len[i] - 1), w_sum});
               end
            end
         end
      end
   end

   // Monitor: compares whatever the DUT presents against the queues
   always @(negedge clk) begin
      if (dout_valid) begin
         if (exp_q.size() == 0) begin
            fail_now("unexpected_byte");
         end else begin
            byte_exp_t e;
            e = exp_q.pop_front();
            check("byte_cycle", cyc, e.cyc);
            check("byte_data", dout_data, e.data);
            check("byte_id", dout_id, e.id);
            check("byte_idx", dout_idx, e.idx);
            check("byte_last", dout_last, e.last);
`ifdef WROM_ARB_CHECKSUM_EN
            if (e.last) check("burst_sum", burst_sum, e.sum);
`endif
         end
      end
      if (err) begin
         if (err_id_q.size() == 0) begin
            fail_now("unexpected_err");
         end else begin
            check("err_cycle", cyc, err_cyc_q.pop_front());
            check("err_id", dout_id, err_id_q.pop_front());
            check("busy_during_err", busy, 0);
         end
      end
      if (err && dout_valid) fail_now("err_with_dout_valid");
      if (rom_en) begin
         if (addr_q.size() == 0) begin
            fail_now("unexpected_rom_en");
         end else begin
            check("addr_cycle", cyc, addr_cyc_q.pop_front());
            check("rom_addr", rom_addr, addr_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) if (remaining[i] <= 0) req_valid[i] = 1'b0;
   endtask

   task automatic request(int i, int base, int len, int n);
      cfg_base[i] = base;
      cfg_len[i]  = len;
      remaining[i] = n;
      req_base[i*ADDR_W +: ADDR_W] = ADDR_W'(base);
      req_len[i*LEN_W +: LEN_W]    = LEN_W'(len);
      req_valid[i] = 1'b1;
   endtask

   function automatic bit all_done();
      for (int i = 0; i < N_REQ; i++) if (remaining[i] > 0) return 1'b0;
      return exp_q.size() == 0 && err_id_q.size() == 0 && addr_q.size() == 0 && !busy;
   endfunction

   task automatic run(string name, int budget);
      int c = 0;
      while (!all_done() && c < budget) begin
         step();
         c++;
      end
      if (c >= budget) fail_now({name, "_timeout"});
      repeat (2) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom_mem[i] = 8'((i * 37 + 11) ^ (i >> 2));
      rom_mem[700] = 8'h01;
      rom_mem[701] = 8'h02;
      rom_mem[702] = 8'h03;
      rom_mem[703] = 8'hFF;
      for (int i = 0; i < N_REQ; i++) begin
         remaining[i] = 0;
         cfg_base[i]  = 0;
         cfg_len[i]   = 0;
      end

      do_reset();
      @(negedge clk);
      check("rst_rom_en", rom_en, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_dout_valid", dout_valid, 0);
      check("rst_dout_id", dout_id, 0);
      check("rst_dout_idx", dout_idx, 0);
      check("rst_dout_last", dout_last, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", req_ready, 0);
      step();

      // Single burst: timing and tags are checked by the scoreboard
      request(0, 0, 9, 1);
      run("single", 60);

      // Fairness: four contenders, requester 0 asks twice
      do_reset();
      gid_q.delete();
      gcyc_q.delete();
      request(0, 100, 4, 2);
      request(1, 200, 4, 1);
      request(2, 300, 4, 1);
      request(3, 400, 4, 1);
      run("fair", 120);
      check("fair_grant_count", gid_q.size(), 5);
      if (gid_q.size() == 5) begin
         check("fair_grant0", gid_q[0], 0);
         check("fair_grant1", gid_q[1], 1);
         check("fair_grant2", gid_q[2], 2);
         check("fair_grant3", gid_q[3], 3);
         check("fair_grant4", gid_q[4], 0);
         for (int g = 1; g < 5; g++) check("fair_spacing", gcyc_q[g] - gcyc_q[g-1], 7);
      end

      // Range error, then the exact upper boundary which is legal
      request(1, 710, 6, 1);
      run("range_err", 30);
      request(1, 709, 6, 1);
      run("range_edge", 40);

      // Zero length from req2 while req3 waits
      request(2, 50, 0, 1);
      request(3, 60, 5, 1);
      run("zero_len", 60);

      // Reset at the fifth issue cycle of a long burst
      request(0, 15, 54, 1);
      begin
         int c = 0;
         while (remaining[0] > 0 && c < 30) begin step(); c++; end
         while (cyc < accept_cyc + 5 && c < 60) begin step(); c++; end
         if (c >= 60) fail_now("midrst_timeout");
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q.delete();
      addr_q.delete();
      addr_cyc_q.delete();
      @(negedge clk);
      check("midrst_dout_valid", dout_valid, 0);
      check("midrst_rom_en", rom_en, 0);
      check("midrst_busy", busy, 0);
      step();
      request(0, 15, 54, 1);
      run("midrst_retry", 120);

      // Bytes 01 02 03 FF sum to 0x05
      request(2, 700, 4, 1);
      run("checksum", 40);
`ifdef WROM_ARB_CHECKSUM_EN
      check("checksum_hold", burst_sum, 8'h05);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired (cycle %0d)", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/weight_rom_arbiter.md
# weight_rom_arbiter

Shares the single 8-bit weight ROM (fixed 2-cycle read latency) between several layer-side requesters. Each requester asks for a byte burst (base address, length). The block arbitrates round-robin, issues one ROM read per cycle, and streams the returned bytes tagged with requester id, byte index and last flag. It sits between `weight_rom` and the per-layer weight/bias/shift loaders, so layers can reload parameters at run time instead of only once after reset.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `ADDR_W`, 10, ROM address width
- `LEN_W`, 10, burst length width
- `ROM_LAT`, 2, ROM read latency in cycles (address to data)
- `TOTAL_BYTES`, 715, valid ROM bytes; addresses ≥ TOTAL_BYTES are illegal
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  N_REQ  per-requester burst request
- `req_ready`  out  N_REQ  one-hot accept; handshake = valid & ready
- `req_base`  in  N_REQ*ADDR_W  packed start addresses, requester i at `[i*ADDR_W +: ADDR_W]`
- `req_len`  in  N_REQ*LEN_W  packed byte counts
- `rom_en`  out  1  ROM read enable
- `rom_addr`  out  ADDR_W  ROM address
- `rom_dout`  in  8  ROM data, valid ROM_LAT cycles after `rom_en`
- `dout_valid`  out  1  byte valid; no backpressure, consumer must accept
- `dout_data`  out  8  byte
- `dout_id`  out  $clog2(N_REQ)  owning requester
- `dout_idx`  out  LEN_W  byte index within the burst, 0-based
- `dout_last`  out  1  final byte of the burst
- `err`  out  1  one-cycle pulse: rejected request; `dout_id` carries the offender
- `busy`  out  1  high outside IDLE

## Operation
- FSM states and transitions:
  - IDLE → ISSUE on an accepted legal request.
  - IDLE → IDLE on an accepted illegal request; `err` pulses the next cycle.
  - ISSUE → DRAIN after the final address is issued.
  - DRAIN → IDLE once the final byte's `dout_valid` has been emitted.
- Arbitration, IDLE only:
  - Search starts at `last_grant+1` mod N_REQ, picking the first asserted `req_valid`.
  - `req_ready` is combinational and one-hot, asserted only in IDLE.
  - `last_grant` updates on every accept, legal or illegal.
- Accept latches `base`, `len` and `id`. Requests are not accepted outside IDLE.
- Illegal request: `len == 0` or `base + len > TOTAL_BYTES`. The sum is computed at ADDR_W+1 bits, so it cannot wrap.
- ISSUE: `rom_en = 1`; `rom_addr = base + k` for k = 0..len-1, one per cycle.
- Tag pipeline carries {valid, id, idx, last} ROM_LAT stages deep, so the tags align with `rom_dout`.
- `dout_data = rom_dout` is unregistered. The tags come from the final pipeline stage.

## Timing
- Accept in cycle T: first `rom_addr` at T+1, first `dout_valid` at T+1+ROM_LAT, `dout_last` at T+len+ROM_LAT.
- Next accept is possible at T+len+ROM_LAT+1.
- Reset values: every output 0; `last_grant = N_REQ-1`, so requester 0 wins first; tag pipeline cleared.
- `rst` mid-burst: FSM returns to IDLE. No `dout_valid` in the cycle after `rst`, and no stale byte is emitted. An interrupted requester must re-request.
- A `req_valid` deasserting while not granted is legal; requesters must hold `req_base` and `req_len` stable while `req_valid` is high.
- `err` and `dout_valid` are never high together.

## Configuration
- `WROM_ARB_CHECKSUM_EN` defined:
  - Adds output `burst_sum[7:0]`, the mod-256 sum of all bytes in the current burst.
  - `burst_sum` is valid in the cycle `dout_last` is high; it is 0 at reset and holds between bursts.
  - The accumulator clears on accept.
- Undefined: port, accumulator and adder are absent; all other behaviour is identical.

## Structure
- Package `wrom_pkg`:
  - FSM state enum (IDLE, ISSUE, DRAIN).
  - Default constants for ROM_LAT, TOTAL_BYTES, ADDR_W.
  - Tag struct {valid, id, idx, last}.
- Sub-module `wrom_tag_pipe`: ROM_LAT-deep, resettable delay line for the tag struct.
- Round-robin pick stays inline.

## Test plan
- Single burst: req0 base=0 len=9 accepted at T → `rom_addr` 0..8 at T+1..T+9; `dout_valid` T+3..T+11 with ROM[0..8]; `dout_idx` 0..8; `dout_last` only at T+11; `dout_id` = 0.
- Fairness: all four requesters hold valid with len=4 → grant order 0,1,2,3,0, each burst 7 cycles apart; no byte of one burst interleaves with another.
- Range error: req1 base=710 len=6 → `req_ready[1]` for one cycle, `err` = 1 with `dout_id` = 1 next cycle, `rom_en` never high, `busy` low.
- Zero length: req2 len=0 → `err` pulse, no `dout_valid`; a subsequent req3 is served normally.
- Reset mid-burst: req0 base=15 len=54, `rst` at the 5th issue cycle → cycle after `rst` has `dout_valid`=0, `rom_en`=0, `busy`=0; re-request completes all 54 bytes correctly.
- Checksum (`WROM_ARB_CHECKSUM_EN`): burst over ROM bytes 01 02 03 FF → `burst_sum` = 0x05 alongside `dout_last`; without the macro the same burst gives identical `dout_*`.
